// File: rtl/mem_subsystem_pkg.sv
// Shared constants for the memory stage: FSM state encodings, default widths, RAM depth.
package mem_subsystem_pkg;

   localparam int unsigned ADDR_W_DEF = 9;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned DEPTH_DEF  = 1 << ADDR_W_DEF;

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_BUSY     = 2'd1;
   localparam logic [1:0] S_DONE     = 2'd2;
   localparam logic [1:0] S_WAIT_REL = 2'd3;

   function automatic int unsigned mem_depth(input int unsigned aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/mem_subsystem_ram.sv
// mem_ram: synchronous single-port RAM, write enable plus registered read that holds when idle.
module mem_ram
   import mem_subsystem_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = mem_depth(ADDR_W);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_subsystem.sv
// mem_subsystem: MAR/MDR, access FSM and RAM for the memory stage.
// Optional wait states are enabled by defining MEM_WAIT_EN.
module mem_subsystem
   import mem_subsystem_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned LATENCY = 2
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [DATA_W-1:0] BusMuxOut,
   input  logic              MARin,
   input  logic              MDRin,
   input  logic              Read,
   input  logic              Write,
   output logic [DATA_W-1:0] MDR_q,
   output logic [ADDR_W-1:0] MAR_q,
   output logic              Busy,
   output logic              Ready
);

   logic [1:0]        state;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] mdr;
   logic              mdr_from_ram;
   logic              accept, commit, commit_write;
   logic              ram_we, ram_re;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

   assign accept = (state == S_IDLE) && (Read || Write);

`ifdef MEM_WAIT_EN
   localparam logic [3:0] RELOAD = 4'(LATENCY - 1);

   logic [3:0]        cnt;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] wbuf;
   logic              acc_write;

   // Address, data and direction are captured at accept so later MARin cannot disturb the access.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         cnt       <= '0;
         acc_addr  <= '0;
         wbuf      <= '0;
         acc_write <= 1'b0;
      end else if (accept) begin
         cnt       <= RELOAD;
         acc_addr  <= mar;
         wbuf      <= BusMuxOut;
         acc_write <= Write;
      end else if (state == S_BUSY && cnt != '0) begin
         cnt <= cnt - 4'd1;
      end
   end

   assign commit       = (state == S_BUSY) && (cnt == '0);
   assign commit_write = acc_write;
   assign ram_addr     = acc_addr;
   assign ram_wdata    = wbuf;
   assign Busy         = (state == S_BUSY);
`else
   assign commit       = accept;
   assign commit_write = Write;
   assign ram_addr     = mar;
   assign ram_wdata    = BusMuxOut;
   assign Busy         = 1'b0;
`endif

   assign ram_we = commit & commit_write;
   assign ram_re = commit & ~commit_write;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
`ifdef MEM_WAIT_EN
               if (accept) state <= S_BUSY;
`else
               if (accept) state <= S_DONE;
`endif
            end
`ifdef MEM_WAIT_EN
            S_BUSY:     if (cnt == '0) state <= S_DONE;
`endif
            S_DONE:     state <= S_WAIT_REL;
            S_WAIT_REL: if (!Read && !Write) state <= S_IDLE;
            default:    state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         mar          <= '0;
         mdr          <= '0;
         mdr_from_ram <= 1'b0;
      end else begin
         if (state == S_IDLE && MARin) mar <= BusMuxOut[ADDR_W-1:0];
         if (ram_re) begin
            mdr_from_ram <= 1'b1;
         end else if (state == S_IDLE && (Write || (MDRin && !Read))) begin
            mdr          <= BusMuxOut;
            mdr_from_ram <= 1'b0;
         end
      end
   end

   mem_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (Clock),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // The RAM read register doubles as MDR after a read; both sources are flops, so MDR_q stays registered.
   assign MDR_q = mdr_from_ram ? ram_rdata : mdr;
   assign MAR_q = mar;
   assign Ready = (state == S_DONE);

endmodule

// File: tb/tb_mem_subsystem.sv
// Directed bench for mem_subsystem; expected timing follows MEM_WAIT_EN when defined.
module tb_mem_subsystem;

   localparam int unsigned ADDR_W = 9;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned LATENCY = 2;
`ifdef MEM_WAIT_EN
   localparam int L_EFF = LATENCY;
`else
   localparam int L_EFF = 0;
`endif

   logic              Clock = 1'b0;
   logic              Reset = 1'b1;
   logic [DATA_W-1:0] BusMuxOut = '0;
   logic              MARin = 1'b0;
   logic              MDRin = 1'b0;
   logic              Read = 1'b0;
   logic              Write = 1'b0;
   logic [DATA_W-1:0] MDR_q;
   logic [ADDR_W-1:0] MAR_q;
   logic              Busy;
   logic              Ready;

   int checks = 0;
   int errors = 0;

   mem_subsystem #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .LATENCY (LATENCY)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .BusMuxOut (BusMuxOut),
      .MARin     (MARin),
      .MDRin     (MDRin),
      .Read      (Read),
      .Write     (Write),
      .MDR_q     (MDR_q),
      .MAR_q     (MAR_q),
      .Busy      (Busy),
      .Ready     (Ready)
   );

   always #5 Clock = ~Clock;

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic load_mar(input logic [DATA_W-1:0] v);
      MARin = 1'b1; BusMuxOut = v; step(); MARin = 1'b0;
   endtask

   task automatic load_mdr(input logic [DATA_W-1:0] v);
      MDRin = 1'b1; BusMuxOut = v; step(); MDRin = 1'b0;
   endtask

   task automatic release_strobes();
      Read = 1'b0; Write = 1'b0; step(); step();
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      step(); step();
      checks++; if (MAR_q !== '0) begin errors++; $display("FAIL reset_mar: got %h expected 000", MAR_q); end
      checks++; if (MDR_q !== '0) begin errors++; $display("FAIL reset_mdr: got %h expected 00000000", MDR_q); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
      checks++; if (Ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", Ready); end
      Reset = 1'b0;
      step();
   endtask

   task automatic test_load();
      load_mar(32'h1234_5055);
      checks++; if (MAR_q !== 9'h055) begin errors++; $display("FAIL load_mar: got %h expected 055", MAR_q); end
      load_mdr(32'hCAFE_F00D);
      checks++; if (MDR_q !== 32'hCAFE_F00D) begin errors++; $display("FAIL load_mdr: got %h expected cafef00d", MDR_q); end
   endtask

   task automatic test_write_read();
      load_mar(32'h0000_0055);
      Write = 1'b1; BusMuxOut = 32'h1234_5678;
      step();
      checks++; if (MDR_q !== 32'h1234_5678) begin errors++; $display("FAIL wr_mdr_latch: got %h expected 12345678", MDR_q); end
      checks++;
      if (Busy !== (L_EFF > 0) || Ready !== (L_EFF == 0)) begin
         errors++; $display("FAIL wr_e0: got busy=%b ready=%b expected busy=%b ready=%b", Busy, Ready, L_EFF > 0, L_EFF == 0);
      end
      for (int k = 1; k <= L_EFF; k++) begin
         step();
         checks++;
         if (Busy !== (k < L_EFF) || Ready !== (k == L_EFF)) begin
            errors++; $display("FAIL wr_e%0d: got busy=%b ready=%b expected busy=%b ready=%b", k, Busy, Ready, k < L_EFF, k == L_EFF);
         end
      end
      Write = 1'b0;
      step();
      checks++; if (Ready !== 1'b0) begin errors++; $display("FAIL wr_ready_pulse: got %b expected 0", Ready); end
      step();
      load_mdr(32'h0);
      checks++; if (MDR_q !== 32'h0) begin errors++; $display("FAIL rd_preclear: got %h expected 00000000", MDR_q); end
      Read = 1'b1;
      step();
      repeat (L_EFF) step();
      checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b expected 1", Ready); end
      checks++; if (MDR_q !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h expected 12345678", MDR_q); end
      release_strobes();
   endtask

   task automatic test_held_strobe();
      int n;
      n = 0;
      Read = 1'b1;
      repeat (6) begin step(); if (Ready === 1'b1) n++; end
      checks++; if (n != 1) begin errors++; $display("FAIL held_pulses: got %0d expected 1", n); end
      Read = 1'b0;
      step();
      n = 0;
      Read = 1'b1;
      repeat (L_EFF + 2) begin step(); if (Ready === 1'b1) n++; end
      checks++; if (n != 1) begin errors++; $display("FAIL rearm_pulses: got %0d expected 1", n); end
      release_strobes();
   endtask

   task automatic test_rw_simul();
      int n;
      logic [DATA_W-1:0] seen;
      n = 0; seen = '0;
      load_mar(32'h0000_01FF);
      Read = 1'b1; Write = 1'b1; BusMuxOut = 32'h0000_00AA;
      repeat (L_EFF + 4) begin step(); if (Ready === 1'b1) begin n++; seen = MDR_q; end end
      checks++; if (n != 1) begin errors++; $display("FAIL rw_pulses: got %0d expected 1", n); end
      checks++; if (seen !== 32'h0000_00AA) begin errors++; $display("FAIL rw_mdr: got %h expected 000000aa", seen); end
      release_strobes();
      load_mdr(32'h0);
      Read = 1'b1;
      step();
      repeat (L_EFF) step();
      checks++; if (Ready !== 1'b1 || MDR_q !== 32'h0000_00AA) begin
         errors++; $display("FAIL rw_readback: got ready=%b data=%h expected ready=1 data=000000aa", Ready, MDR_q);
      end
      release_strobes();
   endtask

   task automatic test_busy_lockout();
      load_mar(32'h0000_0055);
      Read = 1'b1;
      step();
      MARin = 1'b1; BusMuxOut = 32'h0000_00AB;
      step();
      MARin = 1'b0;
      checks++; if (MAR_q !== 9'h055) begin errors++; $display("FAIL lock_mar: got %h expected 055", MAR_q); end
      MDRin = 1'b1; BusMuxOut = 32'hFFFF_FFFF;
      step();
      MDRin = 1'b0;
      checks++; if (MDR_q !== 32'h1234_5678) begin errors++; $display("FAIL lock_mdr: got %h expected 12345678", MDR_q); end
      release_strobes();
      checks++; if (MAR_q !== 9'h055) begin errors++; $display("FAIL lock_mar_after: got %h expected 055", MAR_q); end
   endtask

`ifdef MEM_WAIT_EN
   task automatic test_reset_mid_write();
      load_mar(32'h0000_0010);
      Write = 1'b1; BusMuxOut = 32'h0;
      repeat (L_EFF + 2) step();
      release_strobes();
      Write = 1'b1; BusMuxOut = 32'hDEAD_BEEF;
      step();
      step();
      Reset = 1'b1; Write = 1'b0;
      #1;
      checks++; if (MAR_q !== '0 || MDR_q !== '0 || Busy !== 1'b0 || Ready !== 1'b0) begin
         errors++; $display("FAIL abort_outputs: got mar=%h mdr=%h busy=%b ready=%b expected all 0", MAR_q, MDR_q, Busy, Ready);
      end
      step();
      Reset = 1'b0;
      repeat (L_EFF + 2) step();
      load_mar(32'h0000_0010);
      load_mdr(32'h0000_0005);
      Read = 1'b1;
      step();
      repeat (L_EFF) step();
      checks++; if (Ready !== 1'b1 || MDR_q !== 32'h0) begin
         errors++; $display("FAIL abort_ram: got ready=%b data=%h expected ready=1 data=00000000", Ready, MDR_q);
      end
      release_strobes();
   endtask
`endif

   initial begin
      test_reset();
      test_load();
      test_write_read();
      test_held_strobe();
      test_rw_simul();
      test_busy_lockout();
`ifdef MEM_WAIT_EN
      test_reset_mid_write();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
